// File: rtl/timer_display.sv
// ---------------------------------------------------------------------------
// timer_display
//
// Purpose:
//   Takes the game's remaining-seconds count and shows it as MM:SS on four
//   active-low 7-segment digits. The binary value is split into minutes and
//   seconds, and then into BCD digits. This is done by a small FSM that
//   repeatedly subtracts, so no divider is needed. A conversion starts only
//   when the input value changes. During the low-time warning window the
//   display blinks once per second pulse. When the value reaches zero, a
//   steady "00:00" is shown and the expired flag is raised.
//
// Ports:
//   Clk        in   system clock (50 MHz)
//   Reset_n    in   asynchronous active-low reset
//   sec        in   one-cycle pulse per second, used only for blinking
//   counter_in in   remaining seconds, unsigned, CNT_W bits
//   HEX3..HEX0 out  active-low segments {g,f,e,d,c,b,a}:
//                   minutes tens, minutes ones, seconds tens, seconds ones
//   done       out  one-cycle pulse when new digits have been registered
//   busy       out  high while the converter FSM is not idle
//   expired    out  the displayed value is zero
//   clamped    out  the last converted input was above MAX_SEC
// ---------------------------------------------------------------------------
module timer_display #(
    parameter int CNT_W    = 32,
    parameter int MAX_SEC  = 5999,
    parameter int WARN_SEC = 10
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             sec,
    input  logic [CNT_W-1:0] counter_in,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX0,
    output logic             done,
    output logic             busy,
    output logic             expired,
    output logic             clamped
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_SEC);
    localparam logic [12:0]      MAX_13   = 13'(MAX_SEC);
    localparam logic [12:0]      WARN_13  = 13'(WARN_SEC);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV60,
        S_BCD_M,
        S_BCD_S,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;

    logic [CNT_W-1:0] r_lastVal;
    logic [CNT_W-1:0] r_snap;
    logic [12:0]      r_rem;
    logic [6:0]       r_mins;
    logic [3:0]       r_mt;
    logic [3:0]       r_st;
    logic             r_clampN;
    logic [12:0]      r_valC;
    logic [12:0]      r_dispVal;
    logic [3:0]       r_dig3;
    logic [3:0]       r_dig2;
    logic [3:0]       r_dig1;
    logic [3:0]       r_dig0;
    logic             r_valid;
    logic             r_done;
    logic             r_busy;
    logic             r_expired;
    logic             r_clamped;
    logic             r_blink;

    logic             w_over;
    logic [12:0]      w_clampVal;
    logic             w_warn;
    logic             w_blank;

    // Active-low segment pattern for a BCD digit; anything else is blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

    // The clamp compare uses the full input width, so very large counts
    // saturate at MAX_SEC and do not wrap into the 13-bit remainder.
    assign w_over     = (r_snap > MAX_CNT);
    assign w_clampVal = w_over ? MAX_13 : r_snap[12:0];

    // The warning window is based on what is shown, not on the raw input.
    assign w_warn  = (r_dispVal != 13'd0) && (r_dispVal <= WARN_13);
    assign w_blank = !r_valid || r_blink;

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic. Each subtract state stays put until its operand
    // drops below the divisor, so the cycle count scales with the digit value.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (counter_in != r_lastVal) w_stateNext = S_LOAD;
            S_LOAD:  w_stateNext = S_DIV60;
            S_DIV60: if (r_rem < 13'd60) w_stateNext = S_BCD_M;
            S_BCD_M: if (r_mins < 7'd10) w_stateNext = S_BCD_S;
            S_BCD_S: if (r_rem < 13'd10) w_stateNext = S_DONE;
            S_DONE:  w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Conversion datapath and output registers. r_lastVal resets to all ones
    // so the first value seen after reset always triggers a conversion. The
    // digits are only loaded in DONE, so a reset part-way through a conversion
    // can never expose partial results.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_lastVal <= '1;
            r_snap    <= '0;
            r_rem     <= '0;
            r_mins    <= '0;
            r_mt      <= '0;
            r_st      <= '0;
            r_clampN  <= 1'b0;
            r_valC    <= '0;
            r_dispVal <= '0;
            r_dig3    <= '0;
            r_dig2    <= '0;
            r_dig1    <= '0;
            r_dig0    <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_expired <= 1'b0;
            r_clamped <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            r_busy <= (w_stateNext != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (counter_in != r_lastVal) begin
                        r_snap    <= counter_in;
                        r_lastVal <= counter_in;
                    end
                end
                S_LOAD: begin
                    r_rem    <= w_clampVal;
                    r_valC   <= w_clampVal;
                    r_mins   <= '0;
                    r_mt     <= '0;
                    r_st     <= '0;
                    r_clampN <= w_over;
                end
                S_DIV60: begin
                    if (r_rem >= 13'd60) begin
                        r_rem  <= r_rem - 13'd60;
                        r_mins <= r_mins + 7'd1;
                    end
                end
                S_BCD_M: begin
                    if (r_mins >= 7'd10) begin
                        r_mins <= r_mins - 7'd10;
                        r_mt   <= r_mt + 4'd1;
                    end
                end
                S_BCD_S: begin
                    if (r_rem >= 13'd10) begin
                        r_rem <= r_rem - 13'd10;
                        r_st  <= r_st + 4'd1;
                    end
                end
                S_DONE: begin
                    r_dig3    <= r_mt;
                    r_dig2    <= r_mins[3:0];
                    r_dig1    <= r_st;
                    r_dig0    <= r_rem[3:0];
                    r_valid   <= 1'b1;
                    r_clamped <= r_clampN;
                    r_expired <= (r_valC == 13'd0);
                    r_dispVal <= r_valC;
                end
                default: ;
            endcase
        end
    end

    // Blink phase. It toggles on each second pulse while inside the warning
    // window. It uses the warn state before any update landing in the same
    // cycle, and it clears one clock after leaving the window, so zero shows
    // steadily.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_blink <= 1'b0;
        end else if (!w_warn) begin
            r_blink <= 1'b0;
        end else if (sec) begin
            r_blink <= ~r_blink;
        end
    end

    assign HEX3    = w_blank ? SEG_OFF : seg7(r_dig3);
    assign HEX2    = w_blank ? SEG_OFF : seg7(r_dig2);
    assign HEX1    = w_blank ? SEG_OFF : seg7(r_dig1);
    assign HEX0    = w_blank ? SEG_OFF : seg7(r_dig0);
    assign done    = r_done;
    assign busy    = r_busy;
    assign expired = r_expired;
    assign clamped = r_clamped;

endmodule

// File: tb/tb_timer_display.sv
// ---------------------------------------------------------------------------
// tb_timer_display
//
// Purpose:
//   Directed self-checking bench for timer_display. Each scenario task drives
//   counter_in and sec on falling clock edges and samples outputs there too.
//   It compares against hand-computed digit patterns and conversion latencies.
// ---------------------------------------------------------------------------
module tb_timer_display;

    localparam logic [27:0] BLANK4 = {7'h7F, 7'h7F, 7'h7F, 7'h7F};

    logic        Clk;
    logic        Reset_n;
    logic        sec;
    logic [31:0] counter_in;
    logic [6:0]  HEX3;
    logic [6:0]  HEX2;
    logic [6:0]  HEX1;
    logic [6:0]  HEX0;
    logic        done;
    logic        busy;
    logic        expired;
    logic        clamped;
    logic [27:0] hexAll;

    int checks   = 0;
    int failures = 0;

    timer_display #(
        .CNT_W   (32),
        .MAX_SEC (5999),
        .WARN_SEC(10)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .sec       (sec),
        .counter_in(counter_in),
        .HEX3      (HEX3),
        .HEX2      (HEX2),
        .HEX1      (HEX1),
        .HEX0      (HEX0),
        .done      (done),
        .busy      (busy),
        .expired   (expired),
        .clamped   (clamped)
    );

    assign hexAll = {HEX3, HEX2, HEX1, HEX0};

    // 100 MHz simulation clock; only cycle counts matter here.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Counts falling edges until done is seen, up to maxCyc. It also counts
    // how many of the edges before done had busy low.
    task automatic waitDone(input int maxCyc, output int cyc, output bit seen,
                            output int busyLow);
        seen    = 1'b0;
        cyc     = 0;
        busyLow = 0;
        while (!seen && cyc < maxCyc) begin
            @(negedge Clk);
            cyc++;
            if (done) seen = 1'b1;
            else if (!busy) busyLow++;
        end
    endtask

    task automatic test_reset();
        Reset_n    = 1'b0;
        sec        = 1'b0;
        counter_in = 32'd125;
        repeat (3) @(negedge Clk);
        checks++;
        if (hexAll !== BLANK4) begin
            failures++;
            $display("[TB] FAIL reset_hex got=%h want=%h", hexAll, BLANK4);
        end
        checks++;
        if ({done, busy, expired, clamped} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b want=0000",
                     {done, busy, expired, clamped});
        end
    endtask

    task automatic test_first_conversion();
        int cyc;
        int blankBad;
        bit seen;
        Reset_n  = 1'b1;
        cyc      = 0;
        blankBad = 0;
        seen     = 1'b0;
        while (!seen && cyc < 50) begin
            @(negedge Clk);
            cyc++;
            if (done) seen = 1'b1;
            else if (hexAll !== BLANK4) blankBad++;
        end
        checks++;
        if (!seen || cyc != 8) begin
            failures++;
            $display("[TB] FAIL first_latency got=%0d seen=%0b want=8", cyc, seen);
        end
        checks++;
        if (blankBad != 0) begin
            failures++;
            $display("[TB] FAIL blank_before_done got=%0d nonblank want=0", blankBad);
        end
        checks++;
        if (hexAll !== {7'h40, 7'h24, 7'h40, 7'h12}) begin
            failures++;
            $display("[TB] FAIL hex_02_05 got=%h want=%h", hexAll,
                     {7'h40, 7'h24, 7'h40, 7'h12});
        end
        checks++;
        if ({expired, clamped} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL flags_125 got=%b want=00", {expired, clamped});
        end
    endtask

    task automatic test_max_latency();
        int cyc;
        int busyLow;
        bit seen;
        counter_in = 32'd5999;
        waitDone(300, cyc, seen, busyLow);
        checks++;
        if (!seen || cyc != 119) begin
            failures++;
            $display("[TB] FAIL latency_5999 got=%0d seen=%0b want=119", cyc, seen);
        end
        checks++;
        if (busyLow != 0) begin
            failures++;
            $display("[TB] FAIL busy_5999 got=%0d low-cycles want=0", busyLow);
        end
        checks++;
        if (hexAll !== {7'h10, 7'h10, 7'h12, 7'h10}) begin
            failures++;
            $display("[TB] FAIL hex_99_59 got=%h want=%h", hexAll,
                     {7'h10, 7'h10, 7'h12, 7'h10});
        end
        @(negedge Clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL idle_after_5999 got=%b want=00", {done, busy});
        end
    endtask

    task automatic test_clamp();
        int cyc;
        int busyLow;
        bit seen;
        counter_in = 32'd100000;
        waitDone(300, cyc, seen, busyLow);
        checks++;
        if (!seen || hexAll !== {7'h10, 7'h10, 7'h12, 7'h10}) begin
            failures++;
            $display("[TB] FAIL hex_clamp got=%h seen=%0b want=%h", hexAll, seen,
                     {7'h10, 7'h10, 7'h12, 7'h10});
        end
        checks++;
        if (clamped !== 1'b1) begin
            failures++;
            $display("[TB] FAIL clamped_set got=%b want=1", clamped);
        end
        @(negedge Clk);
        counter_in = 32'd59;
        waitDone(100, cyc, seen, busyLow);
        checks++;
        if (!seen || cyc != 11) begin
            failures++;
            $display("[TB] FAIL latency_59 got=%0d seen=%0b want=11", cyc, seen);
        end
        checks++;
        if (hexAll !== {7'h40, 7'h40, 7'h12, 7'h10}) begin
            failures++;
            $display("[TB] FAIL hex_00_59 got=%h want=%h", hexAll,
                     {7'h40, 7'h40, 7'h12, 7'h10});
        end
        checks++;
        if (clamped !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clamped_clear got=%b want=0", clamped);
        end
    endtask

    task automatic test_blink_expire();
        int cyc;
        int busyLow;
        bit seen;
        @(negedge Clk);
        counter_in = 32'd5;
        waitDone(100, cyc, seen, busyLow);
        checks++;
        if (!seen || hexAll !== {7'h40, 7'h40, 7'h40, 7'h12}) begin
            failures++;
            $display("[TB] FAIL hex_00_05 got=%h seen=%0b want=%h", hexAll, seen,
                     {7'h40, 7'h40, 7'h40, 7'h12});
        end
        repeat (3) @(negedge Clk);
        sec = 1'b1;
        @(negedge Clk);
        sec = 1'b0;
        checks++;
        if (hexAll !== BLANK4) begin
            failures++;
            $display("[TB] FAIL blink_off got=%h want=%h", hexAll, BLANK4);
        end
        repeat (4) @(negedge Clk);
        checks++;
        if (hexAll !== BLANK4) begin
            failures++;
            $display("[TB] FAIL blink_hold got=%h want=%h", hexAll, BLANK4);
        end
        sec = 1'b1;
        @(negedge Clk);
        sec = 1'b0;
        checks++;
        if (hexAll !== {7'h40, 7'h40, 7'h40, 7'h12}) begin
            failures++;
            $display("[TB] FAIL blink_on got=%h want=%h", hexAll,
                     {7'h40, 7'h40, 7'h40, 7'h12});
        end
        // Go back into the blank phase before expiring, so that zero is
        // forced back to visible.
        sec = 1'b1;
        @(negedge Clk);
        sec = 1'b0;
        counter_in = 32'd0;
        waitDone(100, cyc, seen, busyLow);
        @(negedge Clk);
        checks++;
        if (!seen || hexAll !== {7'h40, 7'h40, 7'h40, 7'h40}) begin
            failures++;
            $display("[TB] FAIL hex_00_00 got=%h seen=%0b want=%h", hexAll, seen,
                     {7'h40, 7'h40, 7'h40, 7'h40});
        end
        checks++;
        if (expired !== 1'b1) begin
            failures++;
            $display("[TB] FAIL expired_set got=%b want=1", expired);
        end
        sec = 1'b1;
        @(negedge Clk);
        sec = 1'b0;
        @(negedge Clk);
        checks++;
        if (hexAll !== {7'h40, 7'h40, 7'h40, 7'h40}) begin
            failures++;
            $display("[TB] FAIL expired_steady got=%h want=%h", hexAll,
                     {7'h40, 7'h40, 7'h40, 7'h40});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int doneCnt;
        int firstAt;
        int secondAt;
        logic [27:0] firstHex;
        counter_in = 32'd300;
        @(negedge Clk);
        counter_in = 32'd299;
        cyc      = 1;
        doneCnt  = 0;
        firstAt  = 0;
        secondAt = 0;
        firstHex = '0;
        while (cyc < 60) begin
            @(negedge Clk);
            cyc++;
            if (done) begin
                doneCnt++;
                if (doneCnt == 1) begin
                    firstAt  = cyc;
                    firstHex = hexAll;
                end else if (doneCnt == 2) begin
                    secondAt = cyc;
                end
            end
        end
        checks++;
        if (doneCnt != 2) begin
            failures++;
            $display("[TB] FAIL b2b_done_count got=%0d want=2", doneCnt);
        end
        checks++;
        if (firstAt != 11 || firstHex !== {7'h40, 7'h12, 7'h40, 7'h40}) begin
            failures++;
            $display("[TB] FAIL b2b_first got=%0d/%h want=11/%h", firstAt, firstHex,
                     {7'h40, 7'h12, 7'h40, 7'h40});
        end
        checks++;
        if (secondAt != 26) begin
            failures++;
            $display("[TB] FAIL b2b_second_at got=%0d want=26", secondAt);
        end
        checks++;
        if (hexAll !== {7'h40, 7'h19, 7'h12, 7'h10} || expired !== 1'b0) begin
            failures++;
            $display("[TB] FAIL hex_04_59 got=%h exp=%b want=%h exp=0", hexAll,
                     expired, {7'h40, 7'h19, 7'h12, 7'h10});
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        int busyLow;
        bit seen;
        counter_in = 32'd5999;
        repeat (20) @(negedge Clk);
        checks++;
        if (busy !== 1'b1 || hexAll !== {7'h40, 7'h19, 7'h12, 7'h10}) begin
            failures++;
            $display("[TB] FAIL mid_pre_reset got=%b/%h want=1/%h", busy, hexAll,
                     {7'h40, 7'h19, 7'h12, 7'h10});
        end
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (hexAll !== BLANK4 || {done, busy, expired, clamped} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL async_reset got=%h/%b want=%h/0000", hexAll,
                     {done, busy, expired, clamped}, BLANK4);
        end
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        waitDone(300, cyc, seen, busyLow);
        checks++;
        if (!seen || cyc != 119) begin
            failures++;
            $display("[TB] FAIL reconvert_latency got=%0d seen=%0b want=119", cyc, seen);
        end
        checks++;
        if (hexAll !== {7'h10, 7'h10, 7'h12, 7'h10} || clamped !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reconvert_hex got=%h clamped=%b want=%h clamped=0",
                     hexAll, clamped, {7'h10, 7'h10, 7'h12, 7'h10});
        end
    endtask

    initial begin
        test_reset();
        test_first_conversion();
        test_max_latency();
        test_clamp();
        test_blink_expire();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_display.md
Name: timer_display

Overview:
- Consumes the game's countdown timer value and one-second pulse from the second counter.
- Converts the value to MM:SS BCD with a sequential subtract-based converter; no combinational divider.
- Drives four active-low 7-segment digits on the board HEX displays.
- Flags expiry and blinks the display during the low-time warning window.

Parameters:
- CNT_W, 32, width of counter_in
- MAX_SEC, 5999, clamp ceiling (99:59)
- WARN_SEC, 10, warning/blink threshold in seconds

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous, active-low reset
- sec  in  1  one-cycle pulse per second from the counter stage
- counter_in  in  CNT_W  remaining seconds, unsigned
- HEX3  out  7  minutes tens, active-low segments {g,f,e,d,c,b,a}
- HEX2  out  7  minutes ones
- HEX1  out  7  seconds tens
- HEX0  out  7  seconds ones
- done  out  1  one-cycle pulse when new digits are registered
- busy  out  1  high while the FSM is not in IDLE
- expired  out  1  displayed value equals 0
- clamped  out  1  last converted input exceeded MAX_SEC

Behaviour:
- Reset (async, Reset_n=0):
  - FSM to IDLE.
  - HEX0..HEX3 = 7'h7F (blank); done = busy = expired = clamped = 0; blink_phase = 0.
  - last_val = all ones, which forces a conversion after reset release.
  - Reset asserted mid-conversion aborts the conversion; no partial digits are ever driven.
- IDLE:
  - If counter_in != last_val: capture snap <= counter_in and last_val <= counter_in, then go to LOAD.
  - The compare happens only in IDLE. Changes during a conversion are picked up on return to IDLE; intermediate values may be skipped.
- LOAD (1 cycle):
  - rem <= min(snap, MAX_SEC); mins <= 0; mt <= 0; st <= 0.
  - clamp_n <= (snap > MAX_SEC).
  - Go to DIV60.
- DIV60:
  - If rem >= 60: rem -= 60, mins++.
  - Else go to BCD_M.
  - Takes M+1 cycles, where M = minutes.
- BCD_M:
  - If mins >= 10: mins -= 10, mt++.
  - Else go to BCD_S.
  - Takes Tm+1 cycles.
- BCD_S:
  - If rem >= 10: rem -= 10, st++.
  - Else go to DONE.
  - Takes Ts+1 cycles.
- DONE (1 cycle):
  - Register digits {mt, mins, st, rem}, clamped <= clamp_n, expired <= (clamped value == 0).
  - done = 1 for exactly this cycle; return to IDLE.
- Latency: L = M + Tm + Ts + 6 rising edges, counted from the IDLE edge that samples the new value to the edge that updates the digits.
  - Worst case: 5999 gives L = 119, far below one second.
- Internal widths:
  - rem: 13 bits; mins: 7 bits; mt/st: 4 bits.
  - All compares and subtractions are unsigned.
  - The clamp compare uses the full CNT_W width.
- Warning blink:
  - warn = displayed value in 1..WARN_SEC.
  - While warn, each sec pulse toggles blink_phase.
  - When not warn, blink_phase is forced to 0 on the next clock.
  - When blink_phase = 1, all HEX outputs are 7'h7F; otherwise the decoded digits are shown.
  - sec arriving in the same cycle as DONE: the toggle uses the warn value before the update.
- Expired: when the value is 0, show "00:00" steady (no blink) and hold expired = 1 until a nonzero value converts.
- Segment encoding for digits 0-9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
- busy is registered: 1 in every state except IDLE.
- sec is otherwise ignored; conversion is driven only by value change.

Test Plan:
- Hold Reset_n=0, then release with counter_in=125 → HEX3..0 = 7'h7F until done; done pulses 8 cycles after the first IDLE sample; then HEX3..0 = 40, 24, 40, 12 ("02:05"); expired = 0; clamped = 0.
- counter_in=5999 → L = 119 cycles; busy high throughout; HEX = 10, 10, 12, 10 ("99:59").
- counter_in=100000 → displays "99:59"; clamped = 1. Then counter_in=59 → "00:59"; clamped = 0.
- counter_in=5, with sec pulses 50M cycles apart → HEX alternates between blank and "00:05" on each sec pulse. Then counter_in=0 → "00:00" steady; expired = 1; no blanking on later sec pulses.
- Change counter_in from 300 to 299 mid-conversion → the 300 result completes with one done pulse; a second conversion of 299 follows immediately; final display "04:59".
- Assert Reset_n=0 in the middle of DIV60 → outputs go blank and flags clear asynchronously. After release, the same counter_in is reconverted and displayed correctly.
